// File: rtl/serial_arbiter_pkg.sv
// Shared types and helpers for the round-robin serial transmitter arbiter.
package serial_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_e;

  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned m);
    return (base + off) % m;
  endfunction

endpackage

// File: rtl/serial_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module serial_rr_pick
  import serial_arbiter_pkg::*;
#(
  parameter int unsigned M = 4,
  parameter int unsigned W = $clog2(M)
) (
  input  logic [M-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  always_comb begin
    logic [W-1:0] c;
    any = 1'b0;
    idx = '0;
    c   = '0;
    for (int unsigned i = 0; i < M; i++) begin
      c = W'(rr_wrap(32'(ptr), i, M));
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/serial_arbiter.sv
// Shares one send/busy serial transmitter between M producers, round-robin,
// forwarding acceptance to the winner only once the transmitter raises busy.
module serial_arbiter
  import serial_arbiter_pkg::*;
#(
  parameter int unsigned M       = 4,
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [M-1:0]         req_send,
  input  logic [M*N-1:0]       req_pdata,
  output logic [M-1:0]         req_busy,
  output logic                 send,
  output logic [N-1:0]         pdata,
  input  logic                 busy,
  output logic [$clog2(M)-1:0] grant_idx,
  input  logic                 err_clr,
  output logic                 timeout_err
);

  localparam int unsigned W  = $clog2(M);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           send_q, send_d;
  logic [N-1:0]   pdata_q, pdata_d;
  logic [M-1:0]   req_busy_q, req_busy_d;
  logic [W-1:0]   grant_q, grant_d;
  logic           err_q, err_d;

  logic           pick_any;
  logic [W-1:0]   pick_idx;
  logic [W-1:0]   ptr_after_grant;

  serial_rr_pick #(.M(M), .W(W)) u_pick (
    .req (req_send),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign ptr_after_grant = W'(rr_wrap(32'(grant_q), 1, M));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    send_d     = send_q;
    pdata_d    = pdata_q;
    req_busy_d = req_busy_q;
    grant_d    = grant_q;
    err_d      = err_q;

    // A timeout set below overrides a same-cycle clear.
    if (err_clr) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!busy && pick_any) begin
          for (int unsigned k = 0; k < M; k++) begin
            if (pick_idx == W'(k)) pdata_d = req_pdata[k*N +: N];
          end
          grant_d = pick_idx;
          send_d  = 1'b1;
          timer_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (busy) begin
          send_d              = 1'b0;
          req_busy_d          = '0;
          req_busy_d[grant_q] = 1'b1;
          state_d             = XFER;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          send_d  = 1'b0;
          err_d   = 1'b1;
          ptr_d   = ptr_after_grant;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      XFER: begin
        if (!busy && !req_send[grant_q]) begin
          req_busy_d = '0;
          ptr_d      = ptr_after_grant;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        send_d     = 1'b0;
        pdata_d    = '0;
        req_busy_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      timer_q    <= '0;
      send_q     <= 1'b0;
      pdata_q    <= '0;
      req_busy_q <= '0;
      grant_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      send_q     <= send_d;
      pdata_q    <= pdata_d;
      req_busy_q <= req_busy_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
    end
  end

  assign req_busy    = req_busy_q;
  assign send        = send_q;
  assign pdata       = pdata_q;
  assign grant_idx   = grant_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_serial_arbiter.sv
// Self-checking bench for serial_arbiter: vector table, directed corner cases,
// and randomized producers/transmitter checked against a transaction-level model.
module tb_serial_arbiter;

  localparam int M = 4, N = 8, TIMEOUT = 15, W = $clog2(M);

  logic           clk = 1'b0;
  logic           rst_l, busy, err_clr, send, timeout_err;
  logic [M-1:0]   req_send, req_busy;
  logic [M*N-1:0] req_pdata;
  logic [N-1:0]   pdata;
  logic [W-1:0]   grant_idx;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  serial_arbiter #(.M(M), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_send    (req_send),
    .req_pdata   (req_pdata),
    .req_busy    (req_busy),
    .send        (send),
    .pdata       (pdata),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [M-1:0] req;
    int           blen;
    logic [W-1:0] exp_g;
    logic [N-1:0] exp_pd;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr(input int p, input logic [M-1:0] r);
    for (int i = 0; i < M; i++) begin
      if (r[(p + i) % M]) return (p + i) % M;
    end
    return -1;
  endfunction

  function automatic logic [M-1:0] onehot(input int g);
    logic [M-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic set_words();
    req_pdata = {8'h43, 8'h32, 8'h21, 8'h10};
  endtask

  task automatic do_reset();
    rst_l    = 1'b0;
    req_send = '0;
    busy     = 1'b0;
    err_clr  = 1'b0;
    req_pdata = '0;
    #12;
    rst_l = 1'b1;
    tick();
  endtask

  task automatic wait_send(input string nm);
    int i;
    i = 0;
    while (send !== 1'b1 && i < 40) begin
      tick();
      i++;
    end
    chk(nm, send, 1);
  endtask

  // random-phase state
  int           pst[M], hold[M], issued[M], accepted[M];
  logic [N-1:0] pw[M];
  int           mptr, cur_g, eg, txs, txd, txl;
  logic [N-1:0] txw;
  logic         send_prev;
  logic [M-1:0] snap;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, rb, other, got, blen, j;

    tbl[0] = '{4'b0100, 2, 2'd2, 8'h32};
    tbl[1] = '{4'b0011, 3, 2'd0, 8'h10};
    tbl[2] = '{4'b1111, 1, 2'd1, 8'h21};
    tbl[3] = '{4'b1001, 2, 2'd3, 8'h43};
    tbl[4] = '{4'b1000, 4, 2'd3, 8'h43};
    tbl[5] = '{4'b0110, 1, 2'd1, 8'h21};
    tbl[6] = '{4'b0001, 2, 2'd0, 8'h10};
    tbl[7] = '{4'b1110, 3, 2'd1, 8'h21};

    // reset values
    do_reset();
    chk("rst_send", send, 0);
    chk("rst_pdata", pdata, 0);
    chk("rst_req_busy", req_busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_err", timeout_err, 0);

    // table: sequential transactions, pointer carried between rows
    set_words();
    for (int i = 0; i < 8; i++) begin
      req_send = tbl[i].req;
      wait_send("tbl_send");
      chk("tbl_grant", grant_idx, tbl[i].exp_g);
      chk("tbl_pdata", pdata, tbl[i].exp_pd);
      chk("tbl_rbusy_pre", req_busy, 0);
      busy = 1'b1;
      tick();
      chk("tbl_rbusy", req_busy, onehot(int'(tbl[i].exp_g)));
      chk("tbl_send_drop", send, 0);
      req_send = '0;
      repeat (tbl[i].blen) tick();
      busy = 1'b0;
      tick();
      chk("tbl_release", req_busy, 0);
    end

    // A: single requester, busy 10 cycles
    do_reset();
    req_pdata[2*N +: N] = 8'hA5;
    req_send = 4'b0100;
    wait_send("A_send");
    chk("A_grant", grant_idx, 2);
    chk("A_pdata", pdata, 8'hA5);
    sc = 1; rb = 0; other = 0;
    busy = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (send) sc++;
      if (req_busy[2]) rb++;
      if ((req_busy & 4'b1011) != 0) other++;
      if (k == 10) busy = 1'b0;
      if (k == 11) req_send = '0;
    end
    chk("A_send_cycles", sc, 1);
    chk("A_rbusy_span", rb, 11);
    chk("A_others", other, 0);

    // B: all four continuously requesting
    do_reset();
    set_words();
    req_send = '1;
    got = 0; blen = 0; j = 0;
    while (got < 12 && j < 400) begin
      tick();
      j++;
      if (send && !busy) begin
        chk("B_order", pdata, 8'h10 + 8'h11 * (got % 4));
        got++;
        busy = 1'b1;
        blen = 2;
      end else if (busy) begin
        if (blen == 0) busy = 1'b0;
        else blen--;
      end
      req_send = ~req_busy;
    end
    chk("B_count", got, 12);
    req_send = '0;
    repeat (6) tick();
    busy = 1'b0;
    repeat (3) tick();

    // C: transmitter never responds
    do_reset();
    set_words();
    req_send = 4'b1010;
    wait_send("C_send");
    chk("C_grant", grant_idx, 1);
    sc = 1; rb = 0; j = 0;
    while (send && j < 40) begin
      tick();
      j++;
      if (send) sc++;
      if (req_busy[1]) rb++;
    end
    chk("C_send_cycles", sc, TIMEOUT);
    chk("C_err", timeout_err, 1);
    chk("C_rbusy1", rb, 0);
    tick();
    chk("C_next_send", send, 1);
    chk("C_next_grant", grant_idx, 3);
    chk("C_next_pdata", pdata, 8'h43);
    busy = 1'b1;
    tick();
    req_send = '0;
    tick();
    busy = 1'b0;
    repeat (2) tick();

    // D: busy holds off grants; then set-wins against err_clr
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("D_clear", timeout_err, 0);
    busy = 1'b1;
    req_send = 4'b0101;
    sc = 0;
    repeat (5) begin
      tick();
      if (send) sc++;
    end
    chk("D_hold", sc, 0);
    busy = 1'b0;
    tick();
    chk("D_grant_next", send, 1);
    chk("D_grant_idx", grant_idx, 0);
    repeat (TIMEOUT - 1) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("D_set_wins", timeout_err, 1);
    chk("D_timeout_send", send, 0);
    req_send = '0;

    // E: asynchronous reset in XFER
    do_reset();
    set_words();
    req_send = 4'b0010;
    wait_send("E_send1");
    busy = 1'b1;
    tick();
    req_send = '0;
    tick();
    busy = 1'b0;
    repeat (2) tick();
    req_send = 4'b1000;
    wait_send("E_send2");
    chk("E_grant2", grant_idx, 3);
    busy = 1'b1;
    tick();
    chk("E_xfer", req_busy, 4'b1000);
    req_send = 4'b1010;
    tick();
    #3 rst_l = 1'b0;
    #1;
    chk("E_rst_send", send, 0);
    chk("E_rst_rbusy", req_busy, 0);
    chk("E_rst_grant", grant_idx, 0);
    chk("E_rst_pdata", pdata, 0);
    chk("E_rst_err", timeout_err, 0);
    #1 rst_l = 1'b1;
    sc = 0;
    repeat (3) begin
      tick();
      if (send) sc++;
    end
    chk("E_busy_hold", sc, 0);
    busy = 1'b0;
    tick();
    chk("E_regrant", send, 1);
    chk("E_regrant_idx", grant_idx, 1);
    busy = 1'b1;
    tick();
    req_send = '0;
    tick();
    busy = 1'b0;
    repeat (2) tick();

    // Random: producers and transmitter against transaction-level model
    do_reset();
    mptr = 0; cur_g = 0; txs = 0; txd = 0; txl = 0; txw = '0;
    for (int k = 0; k < M; k++) begin
      pst[k] = 0; hold[k] = 0; issued[k] = 0; accepted[k] = 0; pw[k] = '0;
    end
    for (int cyc = 0; cyc < 3500; cyc++) begin
      snap = req_send;
      send_prev = send;
      tick();
      if (!send_prev && send) begin
        chk("R_req_at_grant", (snap != 0), 1);
        eg = rr(mptr, snap);
        if (eg >= 0) begin
          chk("R_grant", grant_idx, eg);
          chk("R_pdata", pdata, pw[eg]);
          cur_g = eg;
          mptr = (eg + 1) % M;
        end
      end
      chk("R_onehot", ($countones(req_busy) <= 1), 1);
      if (req_busy != 0) chk("R_rb_owner", req_busy, onehot(cur_g));
      if (txs == 0 && send) begin
        txw = pdata;
        txd = $urandom_range(0, 3);
        txs = 1;
      end
      if (txs == 1) begin
        if (txd == 0) begin
          chk("R_hold", pdata, txw);
          busy = 1'b1;
          txl = $urandom_range(1, 6);
          txs = 2;
        end else txd--;
      end else if (txs == 2) begin
        if (txl == 0) begin
          busy = 1'b0;
          txs = 0;
        end else txl--;
      end
      for (int k = 0; k < M; k++) begin
        case (pst[k])
          0: if (cyc < 3000 && $urandom_range(0, 3) == 0) begin
            pw[k] = N'($urandom);
            req_pdata[k*N +: N] = pw[k];
            req_send[k] = 1'b1;
            issued[k]++;
            pst[k] = 1;
          end
          1: if (req_busy[k]) begin
            chk("R_acc_word", txw, pw[k]);
            accepted[k]++;
            hold[k] = $urandom_range(0, 2);
            pst[k] = 2;
          end
          2: if (hold[k] == 0) begin
            req_send[k] = 1'b0;
            pst[k] = 3;
          end else hold[k]--;
          default: if (!req_busy[k]) pst[k] = 0;
        endcase
      end
    end
    for (int k = 0; k < M; k++) chk("R_count", accepted[k], issued[k]);
    chk("R_drained", req_busy, 0);
    chk("R_no_err", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
